mem_port_arb: RTL and testbench

Arbiter that shares one memory read port between an instruction requester and a data requester. It sits between the fetch/load units and a single-ported `mem` read channel. Each transaction is sequenced through a fixed issue/wait protocol and the result is broadcast with a source tag. Data has priority, bounded by an anti-starvation streak limit, and a watchdog aborts transactions the memory never completes.

---
 rtl/mem_port_arb.sv | 95 +++++++++
 tb/tb_mem_port_arb.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arb.sv
// mem_port_arb: shares one memory read port between instruction and data requesters,
// data first with an anti-starvation streak limit, plus a completion watchdog.
module mem_port_arb #(
    parameter int STARVE  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ireq,
    input  logic [15:0] iaddr,
    output logic        iack,
    input  logic        dreq,
    input  logic [15:0] daddr,
    output logic        dack,
    output logic        mem_re,
    output logic [15:0] mem_raddr,
    input  logic        mem_ready,
    input  logic [15:0] mem_rdata,
    output logic        ready,
    output logic        rsrc,
    output logic [15:0] raddr_out,
    output logic [15:0] rdata,
    output logic        err
);
    localparam int SW = $clog2(STARVE + 1);
    localparam int TW = $clog2(TIMEOUT);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
    state_t        r_state;
    logic [SW-1:0] r_streak;
    logic [TW-1:0] r_timer;
    logic [15:0]   r_addr;
    logic          r_src;
    logic          w_grant_d;
    logic          w_grant_i;
    // data wins unless the instruction side has waited through a full streak
    assign w_grant_d = dreq && !(ireq && r_streak >= SW'(STARVE));
    assign w_grant_i = ireq && !w_grant_d;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_streak  <= '0;
            r_timer   <= '0;
            r_addr    <= '0;
            r_src     <= 1'b0;
            iack      <= 1'b0;
            dack      <= 1'b0;
            mem_re    <= 1'b0;
            mem_raddr <= '0;
            ready     <= 1'b0;
            rsrc      <= 1'b0;
            raddr_out <= '0;
            rdata     <= '0;
            err       <= 1'b0;
        end else begin
            iack  <= 1'b0;
            dack  <= 1'b0;
            ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_d || w_grant_i) begin
                        r_addr   <= w_grant_d ? daddr : iaddr;
                        r_src    <= w_grant_d;
                        dack     <= w_grant_d;
                        iack     <= w_grant_i;
                        r_streak <= (w_grant_d && ireq) ? ((r_streak == SW'(STARVE)) ? r_streak : r_streak + 1'b1) : '0;
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    mem_re    <= 1'b1;
                    mem_raddr <= r_addr;
                    r_timer   <= '0;
                    r_state   <= S_WAIT;
                end
                S_WAIT: begin
                    mem_re <= 1'b0;
                    // completion takes precedence over an expiring watchdog
                    if (mem_ready) begin
                        ready     <= 1'b1;
                        rdata     <= mem_rdata;
                        raddr_out <= r_addr;
                        rsrc      <= r_src;
                        r_state   <= S_IDLE;
                    end else if (r_timer == TW'(TIMEOUT - 1)) begin
                        err     <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arb.sv
// tb_mem_port_arb: bench acting as both requesters and the memory, checked against a
// transaction-level model of grant order, streak, results and the sticky error.
module tb_mem_port_arb;
    localparam int STARVE  = 4;
    localparam int TIMEOUT = 64;
    logic        clk = 1'b0;
    logic        rst;
    logic        ireq, dreq, mem_ready;
    logic [15:0] iaddr, daddr, mem_rdata;
    logic        iack, dack, mem_re, ready, rsrc, err;
    logic [15:0] mem_raddr, raddr_out, rdata;
    int          ncmp = 0;
    int          nerr = 0;
    int          streak;
    bit          exp_err;
    logic [15:0] last_addr, last_data, cur_addr;
    logic        last_src, cur_src;
    string       seq;

    always #5 clk = ~clk;

    mem_port_arb #(.STARVE(STARVE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .ireq(ireq), .iaddr(iaddr), .iack(iack),
        .dreq(dreq), .daddr(daddr), .dack(dack),
        .mem_re(mem_re), .mem_raddr(mem_raddr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .ready(ready), .rsrc(rsrc), .raddr_out(raddr_out), .rdata(rdata), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_iack"}, {31'd0, iack}, 0);
        chk({tag, "_dack"}, {31'd0, dack}, 0);
        chk({tag, "_mem_re"}, {31'd0, mem_re}, 0);
        chk({tag, "_mem_raddr"}, {16'd0, mem_raddr}, 0);
        chk({tag, "_ready"}, {31'd0, ready}, 0);
        chk({tag, "_rsrc"}, {31'd0, rsrc}, 0);
        chk({tag, "_raddr_out"}, {16'd0, raddr_out}, 0);
        chk({tag, "_rdata"}, {16'd0, rdata}, 0);
        chk({tag, "_err"}, {31'd0, err}, 0);
    endtask

    task automatic raise(input bit i, input bit d);
        if (i && !ireq) begin ireq = 1'b1; iaddr = 16'($urandom); end
        if (d && !dreq) begin dreq = 1'b1; daddr = 16'($urandom); end
    endtask

    // Called on a negedge while the arbiter idles; the grant is due on the next edge.
    task automatic grant_phase();
        bit exp_d;
        int n;
        exp_d    = dreq && !(ireq && streak >= STARVE);
        cur_addr = exp_d ? daddr : iaddr;
        cur_src  = exp_d;
        streak   = (exp_d && ireq) ? ((streak < STARVE) ? streak + 1 : streak) : 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(iack || dack) && n < 8);
        chk("grant_latency", n, 1);
        chk("dack", {31'd0, dack}, {31'd0, exp_d});
        chk("iack", {31'd0, iack}, {31'd0, !exp_d});
        seq = {seq, dack ? "D" : "I"};
        if (exp_d) dreq = 1'b0; else ireq = 1'b0;
        @(negedge clk);
        chk("mem_re_pulse", {31'd0, mem_re}, 1);
        chk("mem_raddr", {16'd0, mem_raddr}, {16'd0, cur_addr});
        chk("ack_one_cycle", {30'd0, iack, dack}, 0);
    endtask

    // lat: extra cycles before mem_ready; negative or >= TIMEOUT means the memory never answers.
    task automatic mem_phase(input int lat, input logic [15:0] data);
        bit done = 1'b0;
        for (int k = 0; k < TIMEOUT && !done; k++) begin
            if (k == lat) begin mem_ready = 1'b1; mem_rdata = data; end
            @(negedge clk);
            chk("mem_re_low", {31'd0, mem_re}, 0);
            if (k == lat) begin
                mem_ready = 1'b0;
                done = 1'b1;
                chk("ready", {31'd0, ready}, 1);
                chk("rsrc", {31'd0, rsrc}, {31'd0, cur_src});
                chk("raddr_out", {16'd0, raddr_out}, {16'd0, cur_addr});
                chk("rdata", {16'd0, rdata}, {16'd0, data});
                chk("err_on_done", {31'd0, err}, {31'd0, exp_err});
                last_addr = cur_addr;
                last_data = data;
                last_src  = cur_src;
            end else begin
                if (k == TIMEOUT - 1) exp_err = 1'b1;
                chk("no_ready", {31'd0, ready}, 0);
                chk("err_wait", {31'd0, err}, {31'd0, exp_err});
            end
        end
        if (!done) begin
            chk("hold_raddr", {16'd0, raddr_out}, {16'd0, last_addr});
            chk("hold_rdata", {16'd0, rdata}, {16'd0, last_data});
            chk("hold_rsrc", {31'd0, rsrc}, {31'd0, last_src});
        end
    endtask

    task automatic txn(input int lat, input logic [15:0] data);
        grant_phase();
        mem_phase(lat, data);
    endtask

    task automatic ensure_pending();
        if (!ireq && !dreq) begin
            if ($urandom_range(0, 1) != 0) raise(1'b1, 1'b0); else raise(1'b0, 1'b1);
        end
    endtask

    initial begin
        rst = 1'b1; ireq = 1'b0; dreq = 1'b0; mem_ready = 1'b0;
        iaddr = '0; daddr = '0; mem_rdata = '0;
        streak = 0; exp_err = 1'b0; seq = "";
        last_addr = '0; last_data = '0; last_src = 1'b0; cur_addr = '0; cur_src = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        ireq = 1'b1; iaddr = 16'h0010;
        txn(1, 16'h1234);
        // simultaneous requests: data first, then instruction
        seq = "";
        raise(1'b1, 1'b1);
        txn(0, 16'($urandom));
        txn(2, 16'($urandom));
        ncmp++;
        assert (seq == "DI") else begin nerr++; $error("FAIL both_order: observed %s expected DI", seq); end
        seq = "";
        for (int t = 0; t < 6; t++) begin
            raise(1'b1, 1'b1);
            txn(0, 16'($urandom));
        end
        ncmp++;
        assert (seq == "DDDDID") else begin nerr++; $error("FAIL starve_order: observed %s expected DDDDID", seq); end
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 1) != 0) raise(1'b1, 1'b0);
            if ($urandom_range(0, 1) != 0) raise(1'b0, 1'b1);
            ensure_pending();
            txn(int'($urandom_range(0, 7)), 16'($urandom));
        end
        ensure_pending();
        txn(TIMEOUT - 1, 16'($urandom));
        while (ireq || dreq) txn(0, 16'($urandom));
        raise(1'b0, 1'b1);
        txn(-1, 16'h0000);
        mem_ready = 1'b1; mem_rdata = 16'hBEEF;
        @(negedge clk);
        chk("late_ready_ignored", {31'd0, ready}, 0);
        chk("late_no_ack", {30'd0, iack, dack}, 0);
        chk("late_no_re", {31'd0, mem_re}, 0);
        mem_ready = 1'b0;
        raise(1'b1, 1'b0);
        txn(2, 16'($urandom));
        raise(1'b0, 1'b1);
        grant_phase();
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_zero("rst_async");
        streak = 0; exp_err = 1'b0;
        last_addr = '0; last_data = '0; last_src = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b1; mem_rdata = 16'h5A5A;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, ready}, 0);
        chk("post_rst_ack", {30'd0, iack, dack}, 0);
        chk("post_rst_raddr", {16'd0, raddr_out}, 0);
        mem_ready = 1'b0;
        raise(1'b1, 1'b0);
        txn(0, 16'($urandom));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish before 500000");
        $fatal(1);
    end
endmodule
